// File: rtl/muldiv_ctrl_pkg.sv
// Shared CPU types for the Execute-stage HI/LO sequencer: op encoding,
// FSM states, divider depth and small sign helpers.
package muldiv_ctrl_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  function automatic logic [31:0] neg32_if(input logic [31:0] x, input logic en);
    return en ? (32'd0 - x) : x;
  endfunction

  function automatic logic [63:0] neg64_if(input logic [63:0] x, input logic en);
    return en ? (64'd0 - x) : x;
  endfunction

  // Magnitude of a two's-complement value; 32'h8000_0000 maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32_if(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider datapath: remainder/quotient registers, one subtract
// step per cycle and the iteration counter that flags the final step.
module muldiv_ctrl_div_iter
  import muldiv_ctrl_pkg::*;
#(
  parameter int ITERS = DIV_ITERS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        clr,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] rem_nxt,
  output logic [31:0] quo_nxt,
  output logic        done
);

  localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic        ge;

  // One restoring step plus register next-state selection.
  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    ge      = (rem_sh >= {1'b0, dvsr_q});
    rem_sub = rem_sh[31:0] - dvsr_q;
    rem_nxt = ge ? rem_sub : rem_sh[31:0];
    quo_nxt = {quo_q[30:0], ge};
    done    = step && (cnt_q == CNT_LAST);

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      rem_d  = 32'd0;
      quo_d  = 32'd0;
      dvsr_d = 32'd0;
      cnt_d  = 5'd0;
    end else if (load) begin
      rem_d  = 32'd0;
      quo_d  = dividend;
      dvsr_d = divisor;
      cnt_d  = 5'd0;
    end else if (step) begin
      rem_d = rem_nxt;
      quo_d = quo_nxt;
      cnt_d = cnt_q + 5'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvsr_q <= 32'd0;
      cnt_q  <= 5'd0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO arithmetic sequencer: accepts MULT/MULTU/DIV/DIVU, stalls the pipe
// while busy and issues a single-cycle HI/LO write with registered results.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DIV_ITERS = muldiv_ctrl_pkg::DIV_ITERS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  md_state_t   state_q, state_d;
  logic        busy_q, busy_d;
  logic        sgn_q, sgn_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        bz_q, bz_d;
  logic [31:0] a_q, a_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  mdop_t       op_in;
  logic        op_sgn;
  logic        abort;
  logic [31:0] a_mag, b_mag;
  logic        div_load, div_clr, div_step, div_done;
  logic [31:0] rem_nxt, quo_nxt;

  muldiv_ctrl_div_iter #(
    .ITERS (DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (div_load),
    .clr      (div_clr),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .rem_nxt  (rem_nxt),
    .quo_nxt  (quo_nxt),
    .done     (div_done)
  );

  // FSM next state, operand capture and result sign fix-up.
  always_comb begin
    op_in  = mdop_t'(op);
    op_sgn = (op_in == MD_MULT) || (op_in == MD_DIV);
    a_mag  = abs32_if(a, op_sgn);
    b_mag  = abs32_if(b, op_sgn);
    abort  = flush && (state_q != ST_IDLE);

    state_d  = state_q;
    sgn_d    = sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bz_d     = bz_q;
    a_d      = a_q;
    prod_d   = prod_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_load = 1'b0;
    div_clr  = 1'b0;
    div_step = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      sgn_d   = 1'b0;
      sa_d    = 1'b0;
      sb_d    = 1'b0;
      bz_d    = 1'b0;
      a_d     = 32'd0;
      prod_d  = 64'd0;
      div_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !flush) begin
            sgn_d = op_sgn;
            sa_d  = op_sgn && a[31];
            sb_d  = op_sgn && b[31];
            bz_d  = (b == 32'd0);
            a_d   = a;
            case (op_in)
              MD_MULT, MD_MULTU: begin
                prod_d  = {32'd0, a_mag} * {32'd0, b_mag};
                state_d = ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                div_load = 1'b1;
                state_d  = ST_DIV;
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          {hi_d, lo_d} = neg64_if(prod_q, sgn_q && (sa_q ^ sb_q));
          state_d      = ST_DONE;
        end
        ST_DIV: begin
          div_step = 1'b1;
          if (div_done) begin
            // A zero divisor overrides the raw divider output for both signednesses.
            lo_d    = bz_q ? 32'hFFFF_FFFF : neg32_if(quo_nxt, sgn_q && (sa_q ^ sb_q));
            hi_d    = bz_q ? a_q : neg32_if(rem_nxt, sgn_q && sa_q);
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIV;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      a_q     <= 32'd0;
      prod_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall drops in DONE so the held instruction retires with the HI/LO write.
  assign stall    = (start && !flush && (state_q == ST_IDLE)) ||
                    (state_q == ST_MUL) || (state_q == ST_DIV);
  assign busy     = busy_q;
  assign hi_write = (state_q == ST_DONE) && !flush;
  assign lo_write = (state_q == ST_DONE) && !flush;
  assign hi_data  = hi_q;
  assign lo_data  = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table with a result scoreboard,
// plus hand sequences for flush, flush-with-start, flush in DONE and reset.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        stall, busy, hi_write, lo_write;
  logic [31:0] hi_data, lo_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    mdop_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  muldiv_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_data  (hi_data),
    .lo_data  (lo_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (hi_write === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", {63'd0, hi_write}, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("hi_data", {32'd0, hi_data}, {32'd0, e[63:32]});
        chk("lo_data", {32'd0, lo_data}, {32'd0, e[31:0]});
        chk("lo_write", {63'd0, lo_write}, 64'd1);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge ending DONE.
  task automatic run_op(input mdop_t o, input logic [31:0] ai, input logic [31:0] bi,
                        input logic [31:0] hi_e, input logic [31:0] lo_e,
                        input int lat_e, input string nm);
    int cyc;
    int st_cnt;
    logic seen;
    sb_q.push_back({hi_e, lo_e});
    op = o; a = ai; b = bi; start = 1'b1;
    cyc = 0; st_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (stall) st_cnt++;
      if (hi_write) begin
        seen = 1'b1;
      end else begin
        cyc++;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, "_latency"}, 64'(cyc), 64'(lat_e));
    chk({nm, "_stall_cycles"}, 64'(st_cnt), 64'(lat_e));
    chk({nm, "_stall_in_done"}, {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input mdop_t o, input logic [31:0] ai, input logic [31:0] bi);
    op = o; a = ai; b = bi; start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 2};
    vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2};
    vecs[2]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2};
    vecs[3]  = '{MD_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 2};
    vecs[4]  = '{MD_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2};
    vecs[5]  = '{MD_MULTU, 32'd7,         32'hFFFF_FFFF, 32'h0000_0006, 32'hFFFF_FFF9, 2};
    vecs[6]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[7]  = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[8]  = '{MD_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 33};
    vecs[9]  = '{MD_DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 33};
    vecs[10] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    vecs[11] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
    vecs[12] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 33};
    vecs[13] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 33};

    // Reset state.
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_strobe", {62'd0, hi_write, lo_write}, 64'd0);
    chk("rst_data", {hi_data, lo_data}, 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, issued back to back.
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // Divide flushed at N+10, then a multiply accepted at N+11.
    start_pulse(MD_DIV, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy_low", {63'd0, busy}, 64'd0);
    run_op(MD_MULT, 32'd6, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFE8, 2, "post_flush_mult");

    // Start and flush together in IDLE: request dropped.
    op = MD_MULTU; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("start_flush_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("start_flush_busy_later", {63'd0, busy}, 64'd0);

    // Flush in DONE suppresses the strobes.
    start_pulse(MD_MULTU, 32'd9, 32'd9);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("done_flush_strobe", {62'd0, hi_write, lo_write}, 64'd0);
    chk("done_flush_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("done_flush_idle", {63'd0, busy}, 64'd0);

    // Reset asserted at N+5 of a divide.
    start_pulse(MD_DIVU, 32'd500, 32'd7);
    repeat (4) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_strobe", {62'd0, hi_write, lo_write}, 64'd0);
    chk("async_rst_stall", {63'd0, stall}, 64'd0);
    chk("async_rst_data", {hi_data, lo_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", {62'd0, busy, hi_write}, 64'd0);
    end
    @(posedge clk);
    #1;
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, "post_rst_divu");

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for HI/LO-producing arithmetic (MULT, MULTU, DIV, DIVU) in the Execute stage of the 5-stage MIPS pipeline. It accepts one operation at a time and runs a single-cycle registered multiply or a 32-iteration restoring divide. While the operation is in flight it holds the pipeline with a stall request. On completion it delivers one-cycle HI/LO write strobes and data to the hilo register file.

## Interface
Parameters:
- DIV_ITERS, 32, number of divide iteration cycles; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- start  in  1  Execute-stage request; sampled only in IDLE.
- op  in  2  mdop_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- a  in  32  rs operand; dividend or multiplicand.
- b  in  32  rt operand; divisor or multiplier.
- flush  in  1  aborts the in-flight or starting operation.
- stall  out  1  pipeline hold request (combinational).
- busy  out  1  registered; high while state != IDLE.
- hi_write, lo_write  out  1 each  one-cycle write strobes, always asserted together.
- hi_data, lo_data  out  32 each  results, valid only when the strobes are high.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE with start & ~flush:
  - Operands are latched.
  - For signed ops, magnitudes and the sign flags sa, sb are latched.
  - MULT/MULTU: the 64-bit product is registered and the state goes to MUL.
  - DIV/DIVU: the iteration counter is loaded with 0 and the state goes to DIV.
- MUL: one cycle, then DONE.
- DIV, one restoring step per cycle:
  - {rem, quo} shifts left by 1.
  - If rem >= |b|, then rem -= |b| and quo[0] = 1.
  - After 32 steps the state goes to DONE.
- DONE:
  - hi_write = lo_write = 1 for exactly this cycle.
  - Multiply: HI = prod[63:32], LO = prod[31:0]. Signed multiply negates the magnitude product when sa ^ sb.
  - Divide: LO = quotient, negated when sa ^ sb (signed only). HI = remainder, negated when sa (signed only).
  - Divide by zero, both signed and unsigned: LO = 32'hFFFF_FFFF, HI = a. The divider still runs all 32 cycles, so latency is uniform.
  - Signed 32'h8000_0000 / -1: LO = 32'h8000_0000, HI = 0. This is the natural wraparound result.
  - The next state is IDLE.
- stall = (start & ~flush & state==IDLE) | (state==MUL) | (state==DIV). stall is low in DONE, so the held instruction advances in the same cycle HI/LO are written.
- start while state != IDLE is ignored. The pipeline stall guarantees no new request appears.
- flush in any non-IDLE state: the next state is IDLE, no strobe is issued, and the latched operands are discarded. flush in DONE suppresses that cycle's strobes.
- flush and start in the same IDLE cycle: the request is not accepted and stall = 0.

## Timing
- Reset values: state = IDLE, counter = 0, all registered datapath = 0. Outputs: stall = 0 (when start = 0), busy = 0, strobes = 0, data = 0.
- Reset mid-operation aborts immediately and asynchronously; no write is ever issued.
- Multiply accepted at cycle N: MUL at N+1, DONE (strobes) at N+2. stall is high in N and N+1.
- Divide accepted at cycle N: DIV from N+1 through N+32, DONE at N+33. stall is high in N..N+32.
- Back-to-back: a new start is accepted in the cycle after DONE, i.e. the first IDLE cycle.
- Iteration counter: 5 bits. It wraps from 31 to the DONE transition; no extra cycle.
- Strobe data is registered; there is no combinational path from a/b to hi_data/lo_data.

## Structure
- mdop_t enum and the DIV_ITERS constant go in the shared CPU type package alongside alu_t and mult_t.
- Sub-module div_iter holds the rem/quo registers, the one-step restoring subtract, and the counter, with a done flag. muldiv_ctrl owns the FSM, the sign fix-up, the multiplier register and the strobes.

## Test plan
- MULT a=32'hFFFF_FFFD (-3), b=5 -> strobes at N+2, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1; stall high exactly 2 cycles.
- MULTU a=b=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- DIV a=-7, b=2 -> strobes at N+33, LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU and DIV with b=0, a=32'h1234_5678 -> LO=32'hFFFF_FFFF, HI=32'h1234_5678 at N+33.
- DIV started, flush at N+10 -> busy low at N+11, no strobe ever. A new MULT started at N+11 completes at N+13 with correct values.
- resetn pulsed low at N+5 of a divide -> busy and strobes are 0 immediately and stay 0 after release until a new start.
